// File: rtl/core_ext_mem_ctrl_pkg.sv
// Shared definitions for the external memory controller: FSM state encoding,
// default wait-state counts and the wait counter width.
// Optional feature macro: CORE_EXT_MEM_CTRL_RMW_EN (read-modify-write bit writes).
package core_ext_mem_ctrl_pkg;

  localparam int unsigned WsCntW       = 4;
  localparam int unsigned DefaultRomWs = 2;
  localparam int unsigned DefaultRamWs = 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSetup = 3'd1;
  localparam logic [2:0] StStrb  = 3'd2;
  localparam logic [2:0] StTurn  = 3'd3;
  localparam logic [2:0] StHold  = 3'd4;

  // Clamp a wait-state parameter to what the counter can hold.
  function automatic logic [WsCntW-1:0] ws_load(input int unsigned ws);
    int unsigned max_ws;
    max_ws = (1 << WsCntW) - 1;
    if (ws > max_ws) begin
      return '1;
    end
    return ws[WsCntW-1:0];
  endfunction

endpackage

// File: rtl/core_ext_mem_ctrl_wait_cnt.sv
// Wait-state down-counter: loads a wait count, decrements once per strobe
// cycle and flags zero. Saturates at zero.
// Optional feature macro of the enclosing block: CORE_EXT_MEM_CTRL_RMW_EN (not used here).
module core_ext_mem_ctrl_wait_cnt
  import core_ext_mem_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [WsCntW-1:0] load_val_i,
  input  logic              dec_i,
  output logic              zero_o
);

  logic [WsCntW-1:0] cnt_q, cnt_d;

  // Load has priority over decrement; never wrap below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WsCntW'(1);
    end
  end

  // Counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/core_ext_mem_ctrl.sv
// External ROM/RAM bus controller. One access at a time: IDLE -> SETUP ->
// STRB (wait states, then ready-extended) -> HOLD (ack) -> IDLE. All outputs
// are registered. ROM writes complete without any strobe.
// Optional feature macro: CORE_EXT_MEM_CTRL_RMW_EN -- single-bit RAM writes run
// as read, TURN (merge), write. Without it bit_i is ignored.
module core_ext_mem_ctrl
  import core_ext_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ROM_WS = DefaultRomWs,
  parameter int unsigned RAM_WS = DefaultRamWs
) (
  input  logic                       ext_mem_ctrl_clk_i,
  input  logic                       ext_mem_ctrl_rst_b_i,
  input  logic                       ext_mem_ctrl_req_i,
  input  logic                       ext_mem_ctrl_ram_i,
  input  logic                       ext_mem_ctrl_wr_i,
  input  logic                       ext_mem_ctrl_bit_i,
  input  logic [$clog2(DATA_W)-1:0]  ext_mem_ctrl_bit_idx_i,
  input  logic [ADDR_W-1:0]          ext_mem_ctrl_addr_i,
  input  logic [DATA_W-1:0]          ext_mem_ctrl_wdata_i,
  input  logic                       ext_mem_ctrl_bus_rdy_i,
  input  logic [DATA_W-1:0]          ext_mem_ctrl_bus_data_i,
  output logic [ADDR_W-1:0]          ext_mem_ctrl_bus_addr_o,
  output logic [DATA_W-1:0]          ext_mem_ctrl_bus_data_o,
  output logic                       ext_mem_ctrl_bus_data_oe_o,
  output logic                       ext_mem_ctrl_bus_rom_rd_b_o,
  output logic                       ext_mem_ctrl_bus_ram_rd_b_o,
  output logic                       ext_mem_ctrl_bus_ram_wr_b_o,
  output logic [DATA_W-1:0]          ext_mem_ctrl_rdata_o,
  output logic                       ext_mem_ctrl_ack_o,
  output logic                       ext_mem_ctrl_busy_o
);

  localparam logic [WsCntW-1:0] RomWsCnt = ws_load(ROM_WS);
  localparam logic [WsCntW-1:0] RamWsCnt = ws_load(RAM_WS);

  logic [2:0]        state_q, state_d;
  logic              ram_q, wr_q;
  logic              accept, req_rmw, is_rmw, strb_wr_d;
  logic              cnt_load, cnt_dec, cnt_zero, strb_done;
  logic [WsCntW-1:0] cnt_val;

  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_data_q, bus_data_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              oe_q, oe_d;
  logic              rom_rd_b_q, rom_rd_b_d;
  logic              ram_rd_b_q, ram_rd_b_d;
  logic              ram_wr_b_q, ram_wr_b_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;

  assign accept    = (state_q == StIdle) && ext_mem_ctrl_req_i;
  assign strb_done = (state_q == StStrb) && cnt_zero && ext_mem_ctrl_bus_rdy_i;

`ifdef CORE_EXT_MEM_CTRL_RMW_EN
  logic                      bit_q, bit_val_q, wr_phase_q, wr_phase_d;
  logic [$clog2(DATA_W)-1:0] bit_idx_q;
  logic [DATA_W-1:0]         merged;

  assign req_rmw    = ext_mem_ctrl_bit_i & ext_mem_ctrl_ram_i & ext_mem_ctrl_wr_i;
  assign is_rmw     = ram_q & wr_q & bit_q;
  // Second strobe of a read-modify-write is the write.
  assign wr_phase_d = accept ? 1'b0 : ((state_q == StTurn) ? 1'b1 : wr_phase_q);
  assign strb_wr_d  = ram_q & wr_q & (~is_rmw | wr_phase_d);

  // Byte just read from the bus with the requested bit replaced.
  always_comb begin
    merged            = ext_mem_ctrl_bus_data_i;
    merged[bit_idx_q] = bit_val_q;
  end

  // Bit-write request fields and phase flag.
  always_ff @(posedge ext_mem_ctrl_clk_i or negedge ext_mem_ctrl_rst_b_i) begin
    if (!ext_mem_ctrl_rst_b_i) begin
      bit_q      <= 1'b0;
      bit_val_q  <= 1'b0;
      bit_idx_q  <= '0;
      wr_phase_q <= 1'b0;
    end else begin
      if (accept) begin
        bit_q     <= ext_mem_ctrl_bit_i;
        bit_val_q <= ext_mem_ctrl_wdata_i[0];
        bit_idx_q <= ext_mem_ctrl_bit_idx_i;
      end
      wr_phase_q <= wr_phase_d;
    end
  end
`else
  logic unused_bit_req;
  assign unused_bit_req = ^{ext_mem_ctrl_bit_i, ext_mem_ctrl_bit_idx_i};
  assign req_rmw        = 1'b0;
  assign is_rmw         = 1'b0;
  assign strb_wr_d      = ram_q & wr_q;
`endif

  // Wait counter reloads on entry to each strobe phase.
  assign cnt_load = ((state_q == StSetup) && (state_d == StStrb)) || (state_q == StTurn);
  assign cnt_val  = ram_q ? RamWsCnt : RomWsCnt;
  assign cnt_dec  = (state_q == StStrb);

  core_ext_mem_ctrl_wait_cnt u_wait_cnt (
    .clk_i      (ext_mem_ctrl_clk_i),
    .rst_ni     (ext_mem_ctrl_rst_b_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (ext_mem_ctrl_req_i) state_d = StSetup;
      StSetup: state_d = (wr_q && !ram_q) ? StHold : StStrb;
      StStrb: begin
        if (strb_done) begin
          state_d = (is_rmw && ram_wr_b_q) ? StTurn : StHold;
        end
      end
      StTurn:  state_d = StStrb;
      StHold:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Registered output values for the cycle after this edge.
  always_comb begin
    bus_addr_d = bus_addr_q;
    bus_data_d = bus_data_q;
    rdata_d    = rdata_q;
    oe_d       = oe_q;
    if (accept) begin
      bus_addr_d = ext_mem_ctrl_addr_i;
      if (ext_mem_ctrl_ram_i && ext_mem_ctrl_wr_i && !req_rmw) begin
        bus_data_d = ext_mem_ctrl_wdata_i;
        oe_d       = 1'b1;
      end
    end
    // A read strobe ends: write strobe is the only one that leaves ram_wr_b high-false.
    if (strb_done && ram_wr_b_q) begin
      rdata_d = ext_mem_ctrl_bus_data_i;
    end
`ifdef CORE_EXT_MEM_CTRL_RMW_EN
    if (strb_done && (state_d == StTurn)) begin
      bus_data_d = merged;
      oe_d       = 1'b1;
    end
    if (state_q == StTurn) begin
      rdata_d = bus_data_q;
    end
`endif
    if (state_q == StHold) begin
      oe_d = 1'b0;
    end
    rom_rd_b_d = ~((state_d == StStrb) & ~ram_q);
    ram_rd_b_d = ~((state_d == StStrb) & ram_q & ~strb_wr_d);
    ram_wr_b_d = ~((state_d == StStrb) & strb_wr_d);
    ack_d      = (state_d == StHold);
    busy_d     = (state_d != StIdle);
  end

  // FSM, latched request and output registers.
  always_ff @(posedge ext_mem_ctrl_clk_i or negedge ext_mem_ctrl_rst_b_i) begin
    if (!ext_mem_ctrl_rst_b_i) begin
      state_q    <= StIdle;
      ram_q      <= 1'b0;
      wr_q       <= 1'b0;
      bus_addr_q <= '0;
      bus_data_q <= '0;
      rdata_q    <= '0;
      oe_q       <= 1'b0;
      rom_rd_b_q <= 1'b1;
      ram_rd_b_q <= 1'b1;
      ram_wr_b_q <= 1'b1;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ram_q <= ext_mem_ctrl_ram_i;
        wr_q  <= ext_mem_ctrl_wr_i;
      end
      bus_addr_q <= bus_addr_d;
      bus_data_q <= bus_data_d;
      rdata_q    <= rdata_d;
      oe_q       <= oe_d;
      rom_rd_b_q <= rom_rd_b_d;
      ram_rd_b_q <= ram_rd_b_d;
      ram_wr_b_q <= ram_wr_b_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
    end
  end

  assign ext_mem_ctrl_bus_addr_o     = bus_addr_q;
  assign ext_mem_ctrl_bus_data_o     = bus_data_q;
  assign ext_mem_ctrl_bus_data_oe_o  = oe_q;
  assign ext_mem_ctrl_bus_rom_rd_b_o = rom_rd_b_q;
  assign ext_mem_ctrl_bus_ram_rd_b_o = ram_rd_b_q;
  assign ext_mem_ctrl_bus_ram_wr_b_o = ram_wr_b_q;
  assign ext_mem_ctrl_rdata_o        = rdata_q;
  assign ext_mem_ctrl_ack_o          = ack_q;
  assign ext_mem_ctrl_busy_o         = busy_q;

endmodule

// File: tb/tb_core_ext_mem_ctrl.sv
// Bench for core_ext_mem_ctrl. A transaction-level model builds the expected
// per-cycle output timeline of each access; every cycle is compared against it.
// Honours CORE_EXT_MEM_CTRL_RMW_EN for the bit-write case.
module tb_core_ext_mem_ctrl;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ROM_WS = 2;
  localparam int unsigned RAM_WS = 1;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        req = 1'b0, ram = 1'b0, wr = 1'b0, bitw = 1'b0;
  logic [2:0]  bit_idx = '0;
  logic [15:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic        rdy = 1'b1;
  logic [7:0]  bus_din = '0;

  logic [15:0] bus_addr;
  logic [7:0]  bus_dout, rdata;
  logic        oe, rom_rd_b, ram_rd_b, ram_wr_b, ack, busy;

  core_ext_mem_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ROM_WS (ROM_WS),
    .RAM_WS (RAM_WS)
  ) dut (
    .ext_mem_ctrl_clk_i          (clk),
    .ext_mem_ctrl_rst_b_i        (rst_b),
    .ext_mem_ctrl_req_i          (req),
    .ext_mem_ctrl_ram_i          (ram),
    .ext_mem_ctrl_wr_i           (wr),
    .ext_mem_ctrl_bit_i          (bitw),
    .ext_mem_ctrl_bit_idx_i      (bit_idx),
    .ext_mem_ctrl_addr_i         (addr),
    .ext_mem_ctrl_wdata_i        (wdata),
    .ext_mem_ctrl_bus_rdy_i      (rdy),
    .ext_mem_ctrl_bus_data_i     (bus_din),
    .ext_mem_ctrl_bus_addr_o     (bus_addr),
    .ext_mem_ctrl_bus_data_o     (bus_dout),
    .ext_mem_ctrl_bus_data_oe_o  (oe),
    .ext_mem_ctrl_bus_rom_rd_b_o (rom_rd_b),
    .ext_mem_ctrl_bus_ram_rd_b_o (ram_rd_b),
    .ext_mem_ctrl_bus_ram_wr_b_o (ram_wr_b),
    .ext_mem_ctrl_rdata_o        (rdata),
    .ext_mem_ctrl_ack_o          (ack),
    .ext_mem_ctrl_busy_o         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rom_b, rd_b, wr_b, ack, busy, oe;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  rdata;
    logic        chk_rd;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_addr = '0;
  logic [7:0]  m_rdata = '0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t idle_rec();
    exp_t e;
    e.rom_b  = 1'b1;
    e.rd_b   = 1'b1;
    e.wr_b   = 1'b1;
    e.ack    = 1'b0;
    e.busy   = 1'b0;
    e.oe     = 1'b0;
    e.addr   = m_addr;
    e.data   = '0;
    e.rdata  = m_rdata;
    e.chk_rd = 1'b1;
    return e;
  endfunction

  // Compare the current cycle's outputs with the model timeline (idle when empty).
  task automatic compare_cycle();
    exp_t e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = idle_rec();
    check("rom_rd_b", rom_rd_b, e.rom_b);
    check("ram_rd_b", ram_rd_b, e.rd_b);
    check("ram_wr_b", ram_wr_b, e.wr_b);
    check("ack", ack, e.ack);
    check("busy", busy, e.busy);
    check("oe", oe, e.oe);
    check("bus_addr", bus_addr, e.addr);
    if (e.oe) check("bus_data_o", bus_dout, e.data);
    if (e.chk_rd) check("rdata", rdata, e.rdata);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Strobe phase: WS unconditional cycles, then extend while ready is low.
  task automatic push_strobe(input exp_t e, input int ws, input logic [31:0] rdy_low,
                             inout int off);
    for (int i = 0; i < ws; i++) begin
      exp_q.push_back(e);
      off++;
    end
    while (rdy_low[off] && off < 31) begin
      exp_q.push_back(e);
      off++;
    end
    exp_q.push_back(e);
    off++;
  endtask

  // Drive one access (req in offset 0) and check it cycle by cycle.
  task automatic run_txn(input logic t_ram, t_wr, t_bit, input logic [2:0] t_idx,
                         input logic [15:0] t_addr, input logic [7:0] t_wdata, t_mem,
                         input logic [31:0] rdy_low, req_pat,
                         output int strb_cnt, ack_off, oe_cnt, output logic [7:0] wr_seen);
    exp_t e;
    int off, hold, ws;
    logic rmw;
    logic [7:0] merged, rd_final;
    ws = t_ram ? RAM_WS : ROM_WS;
`ifdef CORE_EXT_MEM_CTRL_RMW_EN
    rmw = t_ram & t_wr & t_bit;
`else
    rmw = 1'b0;
`endif
    merged = t_mem;
    merged[t_idx] = t_wdata[0];
    rd_final = m_rdata;
    exp_q.push_back(idle_rec());
    e = idle_rec();
    e.busy = 1'b1;
    e.addr = t_addr;
    e.oe   = t_ram & t_wr & ~rmw;
    e.data = t_wdata;
    exp_q.push_back(e);
    off = 2;
    if (!(t_wr && !t_ram)) begin
      if (!t_wr || rmw) begin
        e.rom_b = t_ram;
        e.rd_b  = ~t_ram;
        e.oe    = 1'b0;
        push_strobe(e, ws, rdy_low, off);
        rd_final = t_mem;
        if (rmw) begin
          e.rom_b = 1'b1;
          e.rd_b = 1'b1;
          e.oe = 1'b1;
          e.data = merged;
          e.chk_rd = 1'b0;
          exp_q.push_back(e);
          off++;
          rd_final = merged;
        end
      end
      if (t_wr) begin
        e.rom_b  = 1'b1;
        e.rd_b   = 1'b1;
        e.wr_b   = 1'b0;
        e.oe     = 1'b1;
        e.data   = rmw ? merged : t_wdata;
        e.rdata  = rd_final;
        e.chk_rd = 1'b1;
        push_strobe(e, ws, rdy_low, off);
      end
    end
    e.rom_b  = 1'b1;
    e.rd_b   = 1'b1;
    e.wr_b   = 1'b1;
    e.ack    = 1'b1;
    e.oe     = t_ram & t_wr;
    e.rdata  = rd_final;
    e.chk_rd = 1'b1;
    exp_q.push_back(e);
    hold = off;
    m_addr  = t_addr;
    m_rdata = rd_final;

    strb_cnt = 0;
    ack_off  = -1;
    oe_cnt   = 0;
    wr_seen  = 'x;
    ram = t_ram; wr = t_wr; bitw = t_bit; bit_idx = t_idx;
    addr = t_addr; wdata = t_wdata; bus_din = t_mem;
    for (int k = 0; k <= hold + 1; k++) begin
      req = req_pat[k];
      rdy = ~rdy_low[k];
      compare_cycle();
      if (!rom_rd_b || !ram_rd_b || !ram_wr_b) strb_cnt++;
      if (ack) ack_off = k;
      if (oe) oe_cnt++;
      if (!ram_wr_b) wr_seen = bus_dout;
      adv();
    end
    req = 1'b0;
    rdy = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, a, o;
    logic [7:0] w;
    exp_t e;

    repeat (2) @(posedge clk);
    #3 rst_b = 1'b1;
    adv();
    check("reset bus_data_o", bus_dout, 8'h00);
    check("reset rdata", rdata, 8'h00);
    check("reset bus_addr", bus_addr, 16'h0000);
    repeat (2) begin
      compare_cycle();
      adv();
    end

    // ROM read, ready low while counter non-zero (ignored).
    run_txn(1'b0, 1'b0, 1'b0, 3'd0, 16'h1234, 8'h00, 8'hA5, 32'h0000_000C, 32'h1, s, a, o, w);
    check("rom read strobe cycles", s, 3);
    check("rom read ack offset", a, 5);
    check("rom read rdata", rdata, 8'hA5);

    // RAM byte write.
    run_txn(1'b1, 1'b1, 1'b0, 3'd0, 16'h00F0, 8'h3C, 8'h00, 32'h0, 32'h1, s, a, o, w);
    check("ram write strobe cycles", s, 2);
    check("ram write ack offset", a, 4);
    check("ram write oe cycles", o, 4);
    check("ram write bus data", w, 8'h3C);
    check("ram write rdata kept", rdata, 8'hA5);

    // RAM read, ready low three cycles once counter is zero.
    run_txn(1'b1, 1'b0, 1'b0, 3'd0, 16'h0456, 8'h00, 8'h5A, 32'h0000_0038, 32'h1, s, a, o, w);
    check("ram read rdy strobe cycles", s, 5);
    check("ram read rdy ack offset", a, 7);
    check("ram read rdy rdata", rdata, 8'h5A);

`ifdef CORE_EXT_MEM_CTRL_RMW_EN
    run_txn(1'b1, 1'b1, 1'b1, 3'd3, 16'h0010, 8'h01, 8'h00, 32'h0, 32'h1, s, a, o, w);
    check("rmw strobe cycles", s, 4);
    check("rmw ack offset", a, 7);
    check("rmw write data", w, 8'h08);
    check("rmw rdata merged", rdata, 8'h08);
    run_txn(1'b1, 1'b1, 1'b1, 3'd6, 16'h0011, 8'h00, 8'hFF, 32'h0, 32'h1, s, a, o, w);
    check("rmw clear bit data", w, 8'hBF);
    check("rmw clear bit rdata", rdata, 8'hBF);
`else
    // Bit write is a plain byte write here.
    run_txn(1'b1, 1'b1, 1'b1, 3'd3, 16'h0010, 8'h81, 8'h00, 32'h0, 32'h1, s, a, o, w);
    check("bit write as byte strobe cycles", s, 2);
    check("bit write as byte ack offset", a, 4);
    check("bit write as byte data", w, 8'h81);
    check("bit write as byte rdata kept", rdata, 8'h5A);
`endif

    // Request toggled while busy is ignored.
    run_txn(1'b0, 1'b0, 1'b0, 3'd0, 16'h0BEE, 8'h00, 8'h77, 32'h0, 32'h0000_001D, s, a, o, w);
    check("busy req strobe cycles", s, 3);
    check("busy req ack offset", a, 5);
    check("busy req rdata", rdata, 8'h77);

    // ROM write: no strobe, ack, rdata unchanged.
    run_txn(1'b0, 1'b1, 1'b0, 3'd0, 16'h2222, 8'hEE, 8'h99, 32'h0, 32'h1, s, a, o, w);
    check("rom write strobe cycles", s, 0);
    check("rom write ack offset", a, 2);
    check("rom write oe cycles", o, 0);
    check("rom write rdata kept", rdata, 8'h77);

    // Reset asserted during a RAM read strobe.
    ram = 1'b1; wr = 1'b0; bitw = 1'b0; addr = 16'h0ABC; bus_din = 8'h11; rdy = 1'b1;
    req = 1'b1;
    exp_q.push_back(idle_rec());
    e = idle_rec();
    e.busy = 1'b1;
    e.addr = 16'h0ABC;
    exp_q.push_back(e);
    e.rd_b = 1'b0;
    exp_q.push_back(e);
    compare_cycle();
    adv();
    req = 1'b0;
    compare_cycle();
    adv();
    compare_cycle();
    #2 rst_b = 1'b0;
    #1;
    check("async reset ram_rd_b", ram_rd_b, 1'b1);
    check("async reset rom_rd_b", rom_rd_b, 1'b1);
    check("async reset ram_wr_b", ram_wr_b, 1'b1);
    check("async reset ack", ack, 1'b0);
    check("async reset busy", busy, 1'b0);
    check("async reset addr", bus_addr, 16'h0000);
    check("async reset rdata", rdata, 8'h00);
    exp_q.delete();
    m_addr = '0;
    m_rdata = '0;
    @(posedge clk);
    #3 rst_b = 1'b1;
    adv();
    repeat (3) begin
      compare_cycle();
      adv();
    end

    run_txn(1'b1, 1'b0, 1'b0, 3'd0, 16'h0ABC, 8'h00, 8'hC3, 32'h0, 32'h1, s, a, o, w);
    check("post reset read strobe cycles", s, 2);
    check("post reset read ack offset", a, 4);
    check("post reset read rdata", rdata, 8'hC3);

    repeat (2) begin
      compare_cycle();
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
